// File: rtl/uart_tx_frm.sv
// UART transmit framer: latches a word on a valid/ready handshake and shifts
// it out LSB first on Txd, framed by a start bit and STOP_BITS stop bits.
// Bit timing comes from Baud_Clk, which pulses OVS times per bit period.
//
// Build option: define UART_TX_PARITY_EN to add the Parity_Odd port and a
// parity bit between the data bits and the stop bit(s).
//
// state  | meaning
// IDLE   | line high, Tx_Ready raised on the second edge in IDLE with En=1
// START  | start bit (low) for OVS pulses
// DATA   | DATA_W data bits, LSB first
// PARITY | parity bit (UART_TX_PARITY_EN builds only)
// STOP   | line high for STOP_BITS*OVS pulses, then back to IDLE
module uart_tx_frm #(
  parameter int DATA_W    = 8,
  parameter int OVS       = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En,
  input  logic              Baud_Clk,
  input  logic [DATA_W-1:0] Tx_Data,
  input  logic              Tx_Valid,
`ifdef UART_TX_PARITY_EN
  input  logic              Parity_Odd,
`endif
  output logic              Tx_Ready,
  output logic              Txd,
  output logic              Busy
);

  localparam int              TW         = $clog2(OVS);
  localparam logic [TW-1:0]   TICK_LAST  = TW'(OVS - 1);
  localparam logic [3:0]      DATA_LAST  = 4'(DATA_W - 1);
  localparam logic [3:0]      STOP_LAST  = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state;
  logic [TW-1:0]       tick_cnt;
  logic [3:0]          bit_cnt;
  logic [DATA_W-1:0]   shift_q;
  // Delays Tx_Ready by one edge after reset or an En abort; a normal frame
  // end arms it directly so Tx_Ready follows one edge after Busy falls.
  logic                ready_arm;
  logic                bit_end;
`ifdef UART_TX_PARITY_EN
  logic                parity_q;
`endif

  // Last Baud_Clk pulse of the current bit period
  assign bit_end = Baud_Clk && (tick_cnt == TICK_LAST);

  // Framer FSM with registered Txd/Busy/Tx_Ready and tick/bit counters
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      ready_arm <= 1'b0;
      Txd       <= 1'b1;
      Tx_Ready  <= 1'b0;
      Busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (!En) begin
      // Abort: drop any partial frame without completing the stop bit
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      ready_arm <= 1'b0;
      Txd       <= 1'b1;
      Tx_Ready  <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Txd      <= 1'b1;
          Busy     <= 1'b0;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (Tx_Valid && Tx_Ready) begin
            shift_q  <= Tx_Data;
`ifdef UART_TX_PARITY_EN
            parity_q <= (^Tx_Data) ^ Parity_Odd;
`endif
            Tx_Ready <= 1'b0;
            Busy     <= 1'b1;
            Txd      <= 1'b0;
            state    <= START;
          end else if (ready_arm) begin
            Tx_Ready <= 1'b1;
          end else begin
            ready_arm <= 1'b1;
          end
        end
        default: begin
          // OVS is a power of two, so the counter wraps to 0 on bit_end
          if (Baud_Clk) tick_cnt <= tick_cnt + TW'(1);
          if (bit_end) begin
            case (state)
              START: begin
                Txd     <= shift_q[0];
                shift_q <= shift_q >> 1;
                state   <= DATA;
              end
              DATA: begin
                if (bit_cnt == DATA_LAST) begin
                  bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                  Txd     <= parity_q;
                  state   <= PARITY;
`else
                  Txd     <= 1'b1;
                  state   <= STOP;
`endif
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                  Txd     <= shift_q[0];
                  shift_q <= shift_q >> 1;
                end
              end
`ifdef UART_TX_PARITY_EN
              PARITY: begin
                Txd   <= 1'b1;
                state <= STOP;
              end
`endif
              STOP: begin
                if (bit_cnt == STOP_LAST) begin
                  bit_cnt   <= '0;
                  Busy      <= 1'b0;
                  ready_arm <= 1'b1;
                  state     <= IDLE;
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frm.sv
// Directed bench for uart_tx_frm: a default instance (8N1, OVS=8) and a
// second instance with OVS=16 and two stop bits share clock, baud and data.
module tb_uart_tx_frm;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       baud;
  logic [7:0] tx_data;
  logic       valid1, valid2;
  logic       parity_odd;
  logic       ready1, txd1, busy1;
  logic       ready2, txd2, busy2;
  logic       sel;
  logic       m_ready, m_txd, m_busy;
  logic       m_valid;
  int         n_tests;
  int         n_fail;
  int         bcnt;

  uart_tx_frm u_dut1 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Baud_Clk(baud),
    .Tx_Data(tx_data), .Tx_Valid(valid1),
`ifdef UART_TX_PARITY_EN
    .Parity_Odd(parity_odd),
`endif
    .Tx_Ready(ready1), .Txd(txd1), .Busy(busy1)
  );

  uart_tx_frm #(.DATA_W(8), .OVS(16), .STOP_BITS(2)) u_dut2 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .Baud_Clk(baud),
    .Tx_Data(tx_data), .Tx_Valid(valid2),
`ifdef UART_TX_PARITY_EN
    .Parity_Odd(parity_odd),
`endif
    .Tx_Ready(ready2), .Txd(txd2), .Busy(busy2)
  );

  assign m_ready = sel ? ready2 : ready1;
  assign m_txd   = sel ? txd2   : txd1;
  assign m_busy  = sel ? busy2  : busy1;
  assign m_valid = sel ? valid2 : valid1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick every 4 clocks, changed just after the rising edge
  initial begin
    bcnt = 0;
    baud = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bcnt = (bcnt + 1) % 4;
      baud = (bcnt == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input int stop);
`ifdef UART_TX_PARITY_EN
    return 10 + stop;
`else
    return 9 + stop;
`endif
  endfunction

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic podd);
    logic [15:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int k = 0; k < 8; k++) b[1+k] = d[k];
`ifdef UART_TX_PARITY_EN
    b[9] = (^d) ^ podd;
`else
    b[9] = b[9] & podd | 1'b1;
`endif
    return b;
  endfunction

  // Called at a negedge with valid already high; returns at the negedge after accept
  task automatic wait_accept(input string tag, input bit hold);
    int n;
    n = 0;
    while (!m_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_seen"}, 32'(m_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      valid1 = 1'b0;
      valid2 = 1'b0;
    end
    check({tag, "_acc_txd"},   32'(m_txd),   32'd0);
    check({tag, "_acc_busy"},  32'(m_busy),  32'd1);
    check({tag, "_acc_ready"}, 32'(m_ready), 32'd0);
  endtask

  // Samples Txd on every Baud_Clk pulse; checks first and last pulse of each bit
  task automatic capture(input string tag, input int ovs, input int nbits, input logic [15:0] exp);
    int p, cyc, first_cyc, last_cyc, b;
    p = 0; cyc = 0; first_cyc = -1; last_cyc = 0;
    while (p < nbits * ovs && cyc < 4000) begin
      if (baud) begin
        p++;
        b = (p - 1) / ovs;
        if ((p - 1) % ovs == 0 || p % ovs == 0)
          check($sformatf("%s_bit%0d", tag, b), 32'(m_txd), 32'(exp[b]));
        if (p == nbits * ovs) check({tag, "_busy_last"}, 32'(m_busy), 32'd1);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_pulses"}, 32'(p), 32'(nbits * ovs));
    check({tag, "_span"}, 32'(last_cyc - first_cyc), 32'((nbits * ovs - 1) * 4));
    check({tag, "_end_busy"},  32'(m_busy),  32'd0);
    check({tag, "_end_txd"},   32'(m_txd),   32'd1);
    check({tag, "_end_ready"}, 32'(m_ready), 32'd0);
  endtask

  initial begin
    int p, g, cyc;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; en = 1'b1; valid1 = 1'b0; valid2 = 1'b0;
    tx_data = 8'h00; parity_odd = 1'b0; sel = 1'b0;

    // Reset and release
    repeat (3) @(negedge clk);
    check("rst_txd",   32'(txd1),   32'd1);
    check("rst_busy",  32'(busy1),  32'd0);
    check("rst_ready", 32'(ready1), 32'd0);
    check("rst_txd2",  32'(txd2),   32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_e1", 32'(ready1), 32'd0);
    @(negedge clk);
    check("rel_ready_e2", 32'(ready1), 32'd1);
    repeat (20) @(negedge clk);
    check("idle_ready", 32'(ready1), 32'd1);
    check("idle_txd",   32'(txd1),   32'd1);
    check("idle_busy",  32'(busy1),  32'd0);

    // Single word 0xA5
    tx_data = 8'hA5; valid1 = 1'b1;
    wait_accept("a5", 1'b0);
    capture("a5", 8, frame_len(1), frame_bits(8'hA5, 1'b0));

    // Back-to-back 0x00 then 0xFF with Tx_Valid held
    @(negedge clk);
    tx_data = 8'h00; valid1 = 1'b1;
    wait_accept("b2b0", 1'b1);
    tx_data = 8'hFF;
    capture("b2b0", 8, frame_len(1), frame_bits(8'h00, 1'b0));
    g = 0;
    while (!m_busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    valid1 = 1'b0;
    check("b2b_gap", 32'(g), 32'd2);
    check("b2b1_acc_txd", 32'(m_txd), 32'd0);
    capture("b2b1", 8, frame_len(1), frame_bits(8'hFF, 1'b0));

    // En dropped inside the 4th data bit of 0x3C
    @(negedge clk);
    tx_data = 8'h3C; valid1 = 1'b1;
    wait_accept("abort", 1'b0);
    p = 0; cyc = 0;
    while (p < 35 && cyc < 1000) begin
      if (baud) p++;
      @(negedge clk);
      cyc++;
    end
    check("abort_busy_pre", 32'(busy1), 32'd1);
    en = 1'b0;
    @(negedge clk);
    check("abort_txd",   32'(txd1),   32'd1);
    check("abort_busy",  32'(busy1),  32'd0);
    check("abort_ready", 32'(ready1), 32'd0);
    repeat (10) @(negedge clk);
    check("abort_hold_ready", 32'(ready1), 32'd0);
    en = 1'b1;
    tx_data = 8'h81; valid1 = 1'b1;
    wait_accept("x81", 1'b0);
    capture("x81", 8, frame_len(1), frame_bits(8'h81, 1'b0));

    // OVS=16, two stop bits, data changed mid-frame
    sel = 1'b1;
    @(negedge clk);
    tx_data = 8'h55; valid2 = 1'b1;
    wait_accept("s2", 1'b0);
    tx_data = 8'hAA;
    capture("s2", 16, frame_len(2), frame_bits(8'h55, 1'b0));
    @(negedge clk);
    check("s2_ready_ret", 32'(m_ready), 32'd1);
    sel = 1'b0;

`ifdef UART_TX_PARITY_EN
    // Parity bit, sampled at accept
    @(negedge clk);
    tx_data = 8'h07; parity_odd = 1'b0; valid1 = 1'b1;
    wait_accept("par_e", 1'b0);
    parity_odd = 1'b1;
    capture("par_e", 8, 11, 16'hFE0E);
    @(negedge clk);
    tx_data = 8'h07; parity_odd = 1'b1; valid1 = 1'b1;
    wait_accept("par_o", 1'b0);
    parity_odd = 1'b0;
    capture("par_o", 8, 11, 16'hFC0E);
`endif

    // Asynchronous reset mid-frame
    @(negedge clk);
    tx_data = 8'hA5; valid1 = 1'b1;
    wait_accept("arst", 1'b0);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_txd",   32'(txd1),   32'd1);
    check("arst_busy",  32'(busy1),  32'd0);
    check("arst_ready", 32'(ready1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
